// File: rtl/sdram_bist_if.sv
// sdram_bist_if: burst handshake between the BIST engine (master) and the SDRAM controller (slave)
// Signals:
//   wr_req/rd_req    master->slave  burst write/read request
//   wr_ack/rd_ack    slave->master  per-word acknowledge
//   wr_addr/rd_addr  master->slave  burst start address
//   wr_len/rd_len    master->slave  burst length
//   wdata            master->slave  write data
//   rdata            slave->master  read data, valid with rd_ack
interface sdram_bist_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
);
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic [DATA_W-1:0] wdata;
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [DATA_W-1:0] rdata;
  modport master (
    output wr_req, wr_addr, wr_len, wdata, rd_req, rd_addr, rd_len,
    input  wr_ack, rd_ack, rdata
  );
  modport slave (
    input  wr_req, wr_addr, wr_len, wdata, rd_req, rd_addr, rd_len,
    output wr_ack, rd_ack, rdata
  );
endinterface

// File: rtl/sdram_bist.sv
// sdram_bist: SDRAM self-test, writes NUM_BURSTS bursts of a pattern then reads them back and compares
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start_i, mode_i    start request and pattern select (0 w, 1 ~w, 2 LFSR, 3 walking one)
//   init_done_i        SDRAM initialisation complete
//   bus                burst handshake to the controller (sdram_bist_if.master)
//   busy_o, done_o     test running / finished (done held until next start)
//   pass_o             done with no mismatches
//   err_count_o        saturating mismatch count
//   first_err_addr_o   address of the first mismatch
//   timeout_o          only with SDRAM_BIST_TIMEOUT_EN: a burst stalled for TIMEOUT cycles
// Optional feature macro: SDRAM_BIST_TIMEOUT_EN
module sdram_bist #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 9,
  parameter int BURST_LEN  = 256,
  parameter int NUM_BURSTS = 4,
  parameter int BASE_ADDR  = 0
`ifdef SDRAM_BIST_TIMEOUT_EN
  , parameter int TIMEOUT  = 65535
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              init_done_i,
  sdram_bist_if.master      bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
`ifdef SDRAM_BIST_TIMEOUT_EN
  , output logic            timeout_o
`endif
);
  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_REQ, WR_DATA, RD_REQ, RD_DATA, DONE} state_t;
  localparam int KW = NUM_BURSTS > 1 ? $clog2(NUM_BURSTS) : 1;
  localparam logic [15:0] SEED = 16'hACE1;
  state_t            state_q;
  logic [1:0]        mode_q;
  logic [KW-1:0]     k_q;
  logic [LEN_W-1:0]  off_q;
  logic [ADDR_W-1:0] w_q, base_q, first_q;
  logic [15:0]       lfsr_q, lfsr_d, err_q, err_d;
  logic [DATA_W-1:0] walk_q, walk_d, pat;
  logic              wr_req_q, rd_req_q, busy_q, done_q, tmo_q;
  logic              in_rd, wr_ack_ok, rd_ack_ok, ack_ok, mismatch, last_w, last_k, tmo_hit;
  always_comb begin
    in_rd = state_q == RD_REQ || state_q == RD_DATA;
    // an ack in a REQ state only counts once the request is actually on the bus
    wr_ack_ok = bus.wr_ack && ((state_q == WR_REQ && wr_req_q) || state_q == WR_DATA);
    rd_ack_ok = bus.rd_ack && ((state_q == RD_REQ && rd_req_q) || state_q == RD_DATA);
    ack_ok = wr_ack_ok || rd_ack_ok;
    pat = mode_q == 2'd0 ? DATA_W'(w_q) :
          mode_q == 2'd1 ? ~DATA_W'(w_q) :
          mode_q == 2'd2 ? DATA_W'(lfsr_q) : walk_q;
    mismatch = rd_ack_ok && bus.rdata != pat;
    err_d = (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
    last_w = off_q == LEN_W'(BURST_LEN - 1);
    last_k = k_q == KW'(NUM_BURSTS - 1);
  end
`ifdef SDRAM_BIST_TIMEOUT_EN
  logic        in_xfer;
  logic [31:0] cnt_q;
  assign in_xfer = in_rd || state_q == WR_REQ || state_q == WR_DATA;
  // reloads on every ack and on the cycle a request is raised
  always_ff @(posedge clk)
    cnt_q <= (!reset_n || !in_xfer || ack_ok || (state_q == WR_REQ && !wr_req_q) ||
              (state_q == RD_REQ && !rd_req_q)) ? '0 : cnt_q + 32'd1;
  assign tmo_hit = in_xfer && !ack_ok && cnt_q >= 32'(TIMEOUT - 1);
  assign timeout_o = tmo_q;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      k_q      <= '0;
      off_q    <= '0;
      w_q      <= '0;
      base_q   <= '0;
      first_q  <= '0;
      err_q    <= '0;
      lfsr_q   <= SEED;
      walk_q   <= DATA_W'(1);
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (mismatch && err_q == '0) first_q <= base_q + ADDR_W'(off_q);
      if (ack_ok) begin
        w_q      <= w_q + ADDR_W'(1);
        off_q    <= off_q + LEN_W'(1);
        lfsr_q   <= lfsr_d;
        walk_q   <= walk_d;
        wr_req_q <= 1'b0;
        rd_req_q <= 1'b0;
      end
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_q <= WAIT_INIT;
          mode_q  <= mode_i;
          err_q   <= '0;
          first_q <= '0;
          k_q     <= '0;
          off_q   <= '0;
          w_q     <= '0;
          base_q  <= ADDR_W'(BASE_ADDR);
          lfsr_q  <= SEED;
          walk_q  <= DATA_W'(1);
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          tmo_q   <= 1'b0;
        end
        WAIT_INIT: if (init_done_i) state_q <= WR_REQ;
        WR_REQ, WR_DATA, RD_REQ, RD_DATA: begin
          // request goes up one cycle after entering the REQ state
          if (state_q == WR_REQ && !wr_req_q) wr_req_q <= 1'b1;
          if (state_q == RD_REQ && !rd_req_q) rd_req_q <= 1'b1;
          if (ack_ok && !last_w) state_q <= in_rd ? RD_DATA : WR_DATA;
          if (ack_ok && last_w) begin
            off_q <= '0;
            if (!last_k) begin
              k_q     <= k_q + KW'(1);
              base_q  <= base_q + ADDR_W'(BURST_LEN);
              state_q <= in_rd ? RD_REQ : WR_REQ;
            end else if (!in_rd) begin
              // rewind so the read phase regenerates the same sequence
              k_q     <= '0;
              w_q     <= '0;
              base_q  <= ADDR_W'(BASE_ADDR);
              lfsr_q  <= SEED;
              walk_q  <= DATA_W'(1);
              state_q <= RD_REQ;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (tmo_hit) begin
        wr_req_q <= 1'b0;
        rd_req_q <= 1'b0;
        state_q  <= DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        tmo_q    <= 1'b1;
      end
    end
  end
  assign bus.wr_req       = wr_req_q;
  assign bus.rd_req       = rd_req_q;
  assign bus.wr_addr      = base_q;
  assign bus.rd_addr      = base_q;
  assign bus.wr_len       = LEN_W'(BURST_LEN);
  assign bus.rd_len       = LEN_W'(BURST_LEN);
  assign bus.wdata        = pat;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = done_q && err_q == '0 && !tmo_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
endmodule

// File: doc/sdram_bist.md
# sdram_bist

Parametrised SDRAM built-in self-test engine that drives the burst handshake of `sdram_top` in place of hand-written test sequencers. On `start` it writes `NUM_BURSTS` bursts of `BURST_LEN` words using a selectable data pattern, then reads every burst back and compares each word against a regenerated expected value. It reports an error count, the first failing address, and pass/fail, and sits between a test/status front end and the SDRAM controller.

## Interface
- `ADDR_W`, 23: SDRAM word address width.
- `DATA_W`, 16: data width.
- `LEN_W`, 9: width of the burst-length fields.
- `BURST_LEN`, 256: words per burst; range 1..2^LEN_W-1.
- `NUM_BURSTS`, 4: bursts per pass; `NUM_BURSTS*BURST_LEN` ≤ 2^ADDR_W.
- `BASE_ADDR`, 0: address of the first burst.
- `clk`  in  1  SDRAM controller clock; all logic on the posedge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a test; ignored while `busy`.
- `mode`  in  2  pattern select, sampled when `start` is accepted.
- `init_done`  in  1  SDRAM initialisation complete.
- `wr_req` / `rd_req`  out  1  burst write / read request.
- `wr_ack` / `rd_ack`  in  1  per-word acknowledge from the controller.
- `wr_addr` / `rd_addr`  out  ADDR_W  burst start address.
- `wr_len` / `rd_len`  out  LEN_W  burst length; constant `BURST_LEN`.
- `wdata`  out  DATA_W  write data.
- `rdata`  in  DATA_W  read data; valid in cycles where `rd_ack`=1.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until the next accepted `start` or reset.
- `pass`  out  1  `done` && `err_count`==0.
- `err_count`  out  16  number of mismatches; saturates at 16'hFFFF.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.

## Operation
- States: IDLE → WAIT_INIT → WR_REQ → WR_DATA → (next burst: WR_REQ | all bursts written: RD_REQ) → RD_DATA → (next burst: RD_REQ | all bursts read: DONE). DONE behaves like IDLE except that `done` stays high.
- IDLE/DONE: `start` latches `mode`, clears `err_count`, `first_err_addr`, the burst index k, the word index w and the pattern generator, then moves to WAIT_INIT.
- WAIT_INIT: waits for `init_done`=1.
- WR_REQ: `wr_req`=1, `wr_addr`=`BASE_ADDR`+k*`BURST_LEN`, `wdata`=pattern(w). Move to WR_DATA on the first `wr_ack`.
- WR_DATA: `wr_req` is low from the cycle after the first ack.
- Each cycle with `wr_ack`=1 consumes one word: w+1, and `wdata` advances on that edge.
- After `BURST_LEN` acks, k+1.
- At the end of the write phase, k, w and the generator are reset to the start state.
- RD_REQ/RD_DATA mirror the write side, using `rd_req`/`rd_ack`/`rd_addr`.
- On each `rd_ack`, compare `rdata` against pattern(w). On a mismatch: `err_count`+1 (saturating), and if this is the first error, `first_err_addr`=burst base+offset.
- Patterns, with w the global word index, truncated to DATA_W:
  - `mode` 0: w.
  - `mode` 1: ~w.
  - `mode` 2: 16-bit LFSR, seed 16'hACE1, next={cur[14:0], cur[15]^cur[13]^cur[12]^cur[10]}, advanced once per word; zero-extended/truncated to DATA_W.
  - `mode` 3: walking one, 1<<(w mod DATA_W).
- Acks received outside WR_DATA/RD_DATA (other than the first ack in the REQ states) are ignored.

## Timing
- Reset values: all outputs 0. `wr_len`/`rd_len` = `BURST_LEN` constant. State IDLE.
- Reset mid-test: the next edge returns to IDLE, drops any request, and clears the results.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle `done` rises.
- The request is asserted the cycle after entering WR_REQ/RD_REQ and held until the first ack.
- The first ack counts as word 0.
- The next request is issued no sooner than one cycle after the last ack of the previous burst.
- The last read ack of the last burst leads to `done`=1, `pass` valid, one cycle later.
- `init_done` dropping mid-test is not monitored.

## Configuration
- `SDRAM_BIST_TIMEOUT_EN` defined:
  - Adds parameter `TIMEOUT`, default 65535, and output `timeout` (1 bit, reset 0).
  - A counter reloads on every ack and request edge.
  - If `TIMEOUT` cycles pass in a REQ/DATA state with no ack, the block drops the request, sets `timeout`=1 and goes to DONE with `pass`=0.
- Undefined: no counter and no port; the block waits indefinitely.

## Test plan
- `BURST_LEN`=8, `NUM_BURSTS`=2, `mode` 0, ideal controller model: writes 0..15 at addresses 0..15; read-back gives `done`=1, `pass`=1, `err_count`=0.
- `mode` 2: first write words 16'hACE1, 16'h59C3; read phase expects the same sequence; pass.
- Model corrupts address 10 (bit 3 flipped) and address 12: `err_count`=2, `first_err_addr`=10, `pass`=0.
- Random 0–5 cycle ack gaps, `init_done` delayed 100 cycles: no requests before `init_done`; each burst has exactly 8 acks; pass.
- `reset_n` low during RD_DATA burst 1: next edge gives `busy`=0, `rd_req`=0, `err_count`=0; a new `start` completes with pass.
- `SDRAM_BIST_TIMEOUT_EN`, `TIMEOUT`=20, model never acks reads: `timeout`=1, `done`=1, `pass`=0, `rd_req`=0.
